// File: rtl/sig_source_pkg.sv
// sig_source_pkg: mode, LFSR tap, throttle seed and FSM encodings for sig_frame_source
package sig_source_pkg;
  localparam logic [1:0] MODE_COUNT = 2'd0;
  localparam logic [1:0] MODE_PRBS = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;
  localparam logic [31:0] DATA_TAPS = 32'h8020_0003;
  localparam logic [15:0] THR_TAPS = 16'hB400;
  localparam logic [15:0] THR_SEED_XOR = 16'hACE1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/sig_lfsr.sv
// sig_lfsr: right-shifting Galois LFSR with synchronous load; a zero seed loads as 1
module sig_lfsr #(
  parameter int W = 32,
  parameter logic [W-1:0] TAPS = '1
) (
  input  logic         a_clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] seed,
  input  logic         step,
  output logic [W-1:0] state
);
  logic [W-1:0] state_d, state_q;
  always_comb begin
    state_d = load ? ((seed == '0) ? W'(1) : seed)
            : step ? ((state_q >> 1) ^ (state_q[0] ? TAPS : '0))
            : state_q;
  end
  always_ff @(posedge a_clk) begin
    if (!rst_n) state_q <= '0;
    else state_q <= state_d;
  end
  assign state = state_q;
endmodule

// File: rtl/sig_frame_source.sv
// sig_frame_source: framed I/Q test-pattern source (COUNT/PRBS/CONST) on a valid/ready/last stream.
// Define SIG_FRAME_SOURCE_THROTTLE_EN to add a pseudo-random valid throttle.
module sig_frame_source
  import sig_source_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCHAN = 1,
  parameter int LENW = 10
) (
  input  logic                   a_clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [LENW-1:0]        len_i,
  input  logic [7:0]             frames_i,
  input  logic [31:0]            seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   m_valid_o,
  input  logic                   m_ready_i,
  output logic                   m_last_o,
  output logic [WIDTH*NCHAN-1:0] m_idata_o,
  output logic [WIDTH*NCHAN-1:0] m_qdata_o
);
  localparam int B = 2 * WIDTH * NCHAN;
  localparam int H = B / 2;
  state_t state_d, state_q;
  logic [1:0] mode_d, mode_q;
  logic [LENW-1:0] len_d, len_q, beat_d, beat_q;
  logic [7:0] frames_d, frames_q, frame_d, frame_q;
  logic [31:0] seed_d, seed_q, prbs, src;
  logic [B-1:0] cnt_d, cnt_q, d;
  logic run, valid, acc, last, ld;
  assign run = state_q == S_RUN;
  assign ld = state_q == S_IDLE && start_i;
  assign acc = valid && m_ready_i;
  assign last = beat_q == len_q - LENW'(1);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    len_d = len_q;
    frames_d = frames_q;
    seed_d = seed_q;
    beat_d = beat_q;
    frame_d = frame_q;
    cnt_d = cnt_q;
    if (ld) begin
      mode_d = mode_i;
      len_d = len_i;
      frames_d = frames_i;
      seed_d = seed_i;
      beat_d = '0;
      frame_d = '0;
      cnt_d = '0;
      state_d = (len_i == '0 || frames_i == '0) ? S_DONE : S_RUN;
    end else if (acc) begin
      cnt_d = cnt_q + B'(1);
      beat_d = last ? '0 : beat_q + LENW'(1);
      frame_d = last ? frame_q + 8'd1 : frame_q;
      state_d = (last && frame_q + 8'd1 == frames_q) ? S_DONE : S_RUN;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge a_clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q <= MODE_COUNT;
      len_q <= '0;
      frames_q <= '0;
      seed_q <= '0;
      beat_q <= '0;
      frame_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      len_q <= len_d;
      frames_q <= frames_d;
      seed_q <= seed_d;
      beat_q <= beat_d;
      frame_q <= frame_d;
      cnt_q <= cnt_d;
    end
  end
  sig_lfsr #(.W(32), .TAPS(DATA_TAPS)) u_data (
    .a_clk(a_clk), .rst_n(rst_n), .load(ld), .seed(seed_i), .step(acc), .state(prbs)
  );
`ifdef SIG_FRAME_SOURCE_THROTTLE_EN
  logic [15:0] thr;
  logic hold_d, hold_q;
  sig_lfsr #(.W(16), .TAPS(THR_TAPS)) u_thr (
    .a_clk(a_clk), .rst_n(rst_n), .load(ld), .seed(seed_i[31:16] ^ THR_SEED_XOR),
    .step(run), .state(thr)
  );
  // a stalled beat stays valid regardless of the throttle bit
  assign valid = run && (hold_q || thr[0]);
  always_comb hold_d = valid && !m_ready_i;
  always_ff @(posedge a_clk) begin
    if (!rst_n) hold_q <= 1'b0;
    else hold_q <= hold_d;
  end
`else
  assign valid = run;
`endif
  // anything above MODE_PRBS, including the reserved code, sends the seed
  assign src = mode_q == MODE_COUNT ? 32'(cnt_q) : mode_q == MODE_PRBS ? prbs : seed_q;
  assign d = src[B-1:0];
  assign busy_o = run;
  assign done_o = state_q == S_DONE;
  assign m_valid_o = valid;
  assign m_last_o = valid && last;
  assign m_idata_o = valid ? d[H-1:0] : '0;
  assign m_qdata_o = valid ? d[B-1:H] : '0;
endmodule

// File: tb/tb_sig_frame_source.sv
// tb_sig_frame_source: scoreboard bench for sig_frame_source with default parameters
module tb_sig_frame_source;
  logic a_clk = 0, rst_n = 0, start_i = 0, m_ready_i = 1;
  logic [1:0] mode_i = 0;
  logic [9:0] len_i = 0;
  logic [7:0] frames_i = 0;
  logic [31:0] seed_i = 0;
  logic busy_o, done_o, m_valid_o, m_last_o;
  logic [3:0] m_idata_o, m_qdata_o;
  int checks = 0, failures = 0, nbeats = 0, fbeats = 0, cur_len = 0;
  bit rnd_ready = 0, stall = 0;
  logic [8:0] prev, e;
  logic [8:0] exp_q[$];

  sig_frame_source dut (
    .a_clk(a_clk), .rst_n(rst_n), .start_i(start_i), .mode_i(mode_i), .len_i(len_i),
    .frames_i(frames_i), .seed_i(seed_i), .busy_o(busy_o), .done_o(done_o),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_last_o(m_last_o),
    .m_idata_o(m_idata_o), .m_qdata_o(m_qdata_o)
  );

  always #5 a_clk = ~a_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic push_run(input logic [1:0] mode, input int len, input int frames, input logic [31:0] seed);
    logic [31:0] s, w;
    int n;
    s = (seed == 0) ? 32'd1 : seed;
    n = 0;
    for (int f = 0; f < frames; f++)
      for (int b = 0; b < len; b++) begin
        w = (mode == 0) ? n : (mode == 1) ? s : seed;
        exp_q.push_back({b == len - 1, w[7:4], w[3:0]});
        n++;
        s = lfsr_step(s);
      end
  endtask

  initial begin
    forever begin
      @(posedge a_clk);
      #1 m_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge a_clk) begin
    if (rst_n) begin
      if (stall) begin
        chk("hold_valid", m_valid_o, 1);
        chk("hold_data", {m_last_o, m_qdata_o, m_idata_o}, prev);
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat", {m_last_o, m_qdata_o, m_idata_o}, e);
        end
        nbeats++;
        fbeats++;
        if (m_last_o) begin
          chk("frame_len", fbeats, cur_len);
          fbeats = 0;
        end
      end
      stall = m_valid_o && !m_ready_i;
      prev = {m_last_o, m_qdata_o, m_idata_o};
    end else begin
      stall = 0;
      fbeats = 0;
    end
  end

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_valid"}, m_valid_o, 0);
    chk({tag, "_last"}, m_last_o, 0);
    chk({tag, "_i"}, m_idata_o, 0);
    chk({tag, "_q"}, m_qdata_o, 0);
  endtask

  task automatic start(input logic [1:0] mode, input int len, input int frames, input logic [31:0] seed);
    @(posedge a_clk);
    #1;
    mode_i = mode;
    len_i = 10'(len);
    frames_i = 8'(frames);
    seed_i = seed;
    start_i = 1;
    @(posedge a_clk);
    #1 start_i = 0;
  endtask

  task automatic run(input logic [1:0] mode, input int len, input int frames, input logic [31:0] seed,
                     input bit rr, input bit poke);
    int cycles, gaps, total;
    total = len * frames;
    rnd_ready = rr;
    nbeats = 0;
    cur_len = len;
    push_run(mode, len, frames, seed);
    start(mode, len, frames, seed);
    chk("start_busy", busy_o, total != 0);
    chk("start_done", done_o, total == 0);
`ifndef SIG_FRAME_SOURCE_THROTTLE_EN
    chk("start_valid", m_valid_o, total != 0);
`endif
    cycles = 0;
    gaps = 0;
    while (!done_o && cycles < 20000) begin
      if (busy_o && !m_valid_o) gaps++;
      @(posedge a_clk);
      #1 cycles++;
      if (poke && cycles == 5) begin
        start_i = 1;
        mode_i = ~mode;
        len_i = 10'd3;
        frames_i = 8'd1;
        seed_i = ~seed;
      end
      if (poke && cycles == 6) start_i = 0;
    end
    if (!done_o) chk("timeout", 0, 1);
    chk("end_busy", busy_o, 0);
    chk("end_valid", m_valid_o, 0);
    chk("beats", nbeats, total);
    chk("queue_left", exp_q.size(), 0);
    if (!rr && total != 0) begin
`ifdef SIG_FRAME_SOURCE_THROTTLE_EN
      chk("gaps_seen", gaps > 0, 1);
`else
      chk("cycles", cycles, total);
`endif
    end
    @(posedge a_clk);
    #1 chk("done_pulse", done_o, 0);
    exp_q.delete();
  endtask

  initial begin
    int cycles;
    repeat (3) @(posedge a_clk);
    #1 chk_idle("reset");
    rst_n = 1;
    run(0, 4, 2, 32'h0, 0, 0);
    run(1, 100, 1, 32'h0, 0, 0);
    run(1, 100, 1, 32'h1, 0, 0);
    run(1, 100, 1, 32'h1, 0, 0);
    run(1, 50, 2, 32'hDEAD_BEEF, 0, 0);
    run(2, 6, 2, 32'hA5C3_1E7F, 0, 0);
    run(3, 5, 1, 32'h0000_0096, 0, 0);
    run(0, 100, 3, 32'h0, 1, 0);
    run(1, 100, 2, 32'h1234_5678, 1, 0);
    run(0, 0, 3, 32'h0, 0, 0);
    run(0, 7, 0, 32'h0, 0, 0);
    run(0, 20, 2, 32'h0, 0, 1);
    run(0, 300, 1, 32'h0, 0, 0);
    rnd_ready = 0;
    nbeats = 0;
    cur_len = 100;
    push_run(0, 100, 1, 32'h0);
    start(0, 100, 1, 32'h0);
    cycles = 0;
    while (nbeats < 50 && cycles < 5000) begin
      @(posedge a_clk);
      #1 cycles++;
    end
    chk("pre_reset_beats", nbeats, 50);
    rst_n = 0;
    @(posedge a_clk);
    #1 chk_idle("midreset");
    rst_n = 1;
    exp_q.delete();
    run(0, 10, 1, 32'h0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sig_frame_source.md
# sig_frame_source

Synthesizable, parametrised frame generator that drives the signal-input port of the correlator with framed I/Q test data over a valid/ready/last stream. Generalises the bench-only random source into an on-chip block for hardware self-test. Adds multi-channel data, runtime frame length and frame count, three data modes and an optional back-pressure throttle. Sits in the `a_clk` domain ahead of the correlator's signal input.

## Interface
- `WIDTH`, 4, bits per I and per Q sample, per channel
- `NCHAN`, 1, channels per beat; constraint `2*WIDTH*NCHAN <= 32`
- `LENW`, 10, width of the frame-length and beat counters

- `a_clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `start_i`  in  1  start request; sampled only in IDLE
- `mode_i`  in  2  0 = COUNT, 1 = PRBS, 2 = CONST, 3 = reserved (behaves as CONST)
- `len_i`  in  LENW  beats per frame
- `frames_i`  in  8  frames per run
- `seed_i`  in  32  PRBS seed or CONST pattern
- `busy_o`  out  1  run in progress
- `done_o`  out  1  one-cycle pulse at end of run
- `m_valid_o`  out  1  beat valid
- `m_ready_i`  in  1  sink ready
- `m_last_o`  out  1  final beat of frame
- `m_idata_o`  out  WIDTH*NCHAN  I samples, channel 0 in the LSBs
- `m_qdata_o`  out  WIDTH*NCHAN  Q samples, channel 0 in the LSBs

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - On `start_i`, latch `mode_i`, `len_i`, `frames_i` and `seed_i`, then go to RUN.
  - If `len_i == 0` or `frames_i == 0`, go to DONE instead; no beats are emitted.
- **RUN**
  - A beat is accepted when `m_valid_o && m_ready_i`.
  - The beat counter increments per accepted beat.
  - `m_last_o` is high on beat index `len-1`.
  - On an accepted last beat: the beat counter clears and the frame counter increments.
  - If the frame counter reaches `frames`, go to DONE.
- **DONE**: assert `done_o` for one cycle, then return to IDLE.
- `start_i` is ignored outside IDLE.
- Latched parameters are immune to input changes during a run.
- **Data modes**
  - Let B = 2*WIDTH*NCHAN and D = the low B bits of the source word.
  - `m_idata_o` = D[B/2-1:0] and `m_qdata_o` = D[B-1:B/2].
  - COUNT: the source word is the running beat number across the whole run, starting at 0 and wrapping modulo 2^B. It does not reset per frame.
  - PRBS: the source word is a 32-bit Galois LFSR with taps 0x80200003.
    - Loaded from the seed at start; a seed of 0 is replaced by 1.
    - Steps once per accepted beat.
  - CONST: the source word is the latched seed on every beat.
- **Stream rules**
  - `m_valid_o` never falls without a handshake.
  - Data and `m_last_o` are stable while `m_valid_o && !m_ready_i`.

## Timing
- Reset values: `busy_o`, `done_o`, `m_valid_o`, `m_last_o` = 0; data = 0; FSM in IDLE; counters = 0.
- Start latency: `start_i` high at edge N (IDLE) gives `busy_o` = 1 and the first beat with `m_valid_o` = 1 after edge N+1.
- Throughput: with `m_ready_i` held high, one beat per cycle, including across frame boundaries (no inter-frame gap).
- End of run: the final last handshake at edge M gives `m_valid_o` = 0, `busy_o` = 0 and `done_o` = 1 after edge M+1. `done_o` clears after M+2.
- Empty run (zero length or zero frames): `done_o` pulses after edge N+1 and `busy_o` stays 0.
- Reset mid-frame: all outputs return to reset values on the next edge and no partial `m_last_o` is emitted.
- Counters wrap only as stated; the beat counter never exceeds `len-1`.

## Configuration
- Macro: `SIG_FRAME_SOURCE_THROTTLE_EN`.
- **Defined**
  - A 16-bit LFSR with taps 0xB400 runs during RUN.
  - Seed is `seed_i[31:16] ^ 16'hACE1`, with 0 replaced by 1.
  - It steps every cycle.
  - `m_valid_o` may rise only in a cycle where LFSR bit 0 is 1. Once high, it is held until the handshake.
- **Undefined**: `m_valid_o` is continuously high in RUN; no throttle logic is built.

## Structure
- Package `sig_source_pkg` holds:
  - mode encoding constants;
  - LFSR tap constants (0x80200003, 0xB400);
  - the throttle seed XOR constant;
  - the FSM state encoding.
- One sub-module, `sig_lfsr`:
  - parameters: width and taps;
  - ports: `load`, `seed`, `step`, `state`;
  - zero-seed substitution done inside;
  - instantiated once for data, and a second time for the throttle when enabled.

## Test plan
- **COUNT, basic:** `len` = 4, `frames` = 2, ready high → 8 consecutive beats with I/Q words 0..7; `m_last_o` on beats 3 and 7; `done_o` one cycle after beat 7.
- **PRBS:** seed 0 → stream identical to a run with seed 1; a second run with seed 1 reproduces the same first 100 beats.
- **Back-pressure:** ready toggled randomly → data and `m_last_o` held stable while stalled; beat count per frame exactly `len` (100).
- **Empty and ignored starts:**
  - `len` = 0 → `done_o` pulse, no `m_valid_o`;
  - `start_i` pulsed mid-run → ignored; run completes unchanged.
- **Reset mid-frame:** `rst_n` low at beat 50 → outputs zero next edge; a fresh start resumes from beat 0.
- **Throttle (`SIG_FRAME_SOURCE_THROTTLE_EN`):** ready held high → gaps present in `m_valid_o`; total beats still `len*frames`; `m_valid_o` never drops without a handshake.
